// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source level/edge capture, mask, fixed priority
// (index 0 highest), claim/EOI in-service tracking with nesting by priority.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            STB_I,
    input  logic            WE_I,
    input  logic [3:2]      ADD_I,
    input  logic [31:0]     DAT_I,
    output logic [31:0]     DAT_O,
    input  logic [NSRC-1:0] IRQ_I,
    output logic            IRQ_O
);

    localparam logic [1:0] ADDR_PEND  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_MODE  = 2'd2;
    localparam logic [1:0] ADDR_CLAIM = 2'd3;

    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] prev;
    logic [NSRC-1:0] insvc;

    logic            cand_vld;
    logic [2:0]      cand;
    logic            cur_vld;
    logic [2:0]      cur;

    logic            bus_wr;
    logic            bus_rd;
    logic            claim;
    logic            eoi;
    logic [NSRC-1:0] claim_vec;
    logic [NSRC-1:0] eoi_vec;
    logic [NSRC-1:0] pend_clr;
    logic [NSRC-1:0] edge_set;
    logic [NSRC-1:0] pend_next;

    // Only DAT_I[NSRC-1:0] and DAT_I[2:0] carry meaning; the rest is ignored.
    logic unused_dat;
    assign unused_dat = &{1'b0, DAT_I[31:8]};

    // Scan from the top so the lowest set index wins.
    always_comb begin
        cand_vld = 1'b0;
        cand     = 3'd0;
        cur_vld  = 1'b0;
        cur      = 3'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending[i] && mask[i]) begin
                cand_vld = 1'b1;
                cand     = 3'(i);
            end
            if (insvc[i]) begin
                cur_vld = 1'b1;
                cur     = 3'(i);
            end
        end
    end

    assign IRQ_O  = cand_vld && (!cur_vld || (cand < cur));

    assign bus_wr = STB_I && WE_I;
    assign bus_rd = STB_I && !WE_I;
    assign claim  = bus_rd && (ADD_I == ADDR_CLAIM) && cand_vld;
    assign eoi    = bus_wr && (ADD_I == ADDR_CLAIM);

    always_comb begin
        claim_vec = '0;
        eoi_vec   = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_vec[i] = claim && (cand == 3'(i));
            eoi_vec[i]   = eoi && (DAT_I[2:0] == 3'(i));
        end
    end

    // Edge sources: a new rising edge beats any clear in the same cycle.
    // Level sources simply follow the input.
    assign edge_set  = IRQ_I & ~prev;
    assign pend_clr  = ((bus_wr && (ADD_I == ADDR_PEND)) ? DAT_I[NSRC-1:0] : '0) | claim_vec;
    assign pend_next = (mode & (edge_set | (pending & ~pend_clr))) | (~mode & IRQ_I);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pending <= '0;
            mask    <= '0;
            mode    <= '0;
            prev    <= '0;
            insvc   <= '0;
        end else begin
            prev    <= IRQ_I;
            pending <= pend_next;
            insvc   <= (insvc | claim_vec) & ~eoi_vec;
            if (bus_wr && (ADD_I == ADDR_MASK)) begin
                mask <= DAT_I[NSRC-1:0];
            end
            if (bus_wr && (ADD_I == ADDR_MODE)) begin
                mode <= DAT_I[NSRC-1:0];
            end
        end
    end

    // Read path ignores STB_I; only the claim side effect needs the strobe.
    always_comb begin
        DAT_O = 32'h0;
        case (ADD_I)
            ADDR_PEND:  DAT_O = {{(32 - NSRC){1'b0}}, pending};
            ADDR_MASK:  DAT_O = {{(32 - NSRC){1'b0}}, mask};
            ADDR_MODE:  DAT_O = {{(32 - NSRC){1'b0}}, mode};
            ADDR_CLAIM: DAT_O = cand_vld ? {1'b1, 28'b0, cand} : 32'h0;
            default:    DAT_O = 32'h0;
        endcase
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have one parameter: NSRC, default 6, number of interrupt sources, legal range 1..8.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports: CLK_I  in  1  clock, all state updates on rising edge.
REQ-004 RST_I  in  1  synchronous active-high reset.
REQ-005 STB_I  in  1  bus access strobe, qualifies WE_I and ADD_I.
REQ-006 WE_I  in  1  write enable; 0 with STB_I=1 means read.
REQ-007 ADD_I  in  2 ([3:2])  word address of the register.
REQ-008 DAT_I  in  32  write data.
REQ-009 DAT_O  out  32  read data, combinational from ADD_I and current state.
REQ-010 IRQ_I  in  NSRC  interrupt requests from device IRQ outputs (timer on bit 0), synchronous to CLK_I.
REQ-011 IRQ_O  out  1  interrupt request to the CPU.

Function
REQ-012 State SHALL be: pending[NSRC], mask[NSRC] (1 = enabled), mode[NSRC] (1 = edge, 0 = level), prev[NSRC] (IRQ_I from the previous cycle), insvc[NSRC] (in service).
REQ-013 Register map SHALL be: ADD_I 0 = PEND, 1 = MASK, 2 = MODE, 3 = CLAIM/EOI; unused high bits read 0.
REQ-014 prev SHALL load IRQ_I every cycle.
REQ-015 Level source i: pending[i] SHALL load IRQ_I[i] every cycle; write-1-to-clear and claim SHALL not affect it.
REQ-016 Edge source i: pending[i] SHALL set when IRQ_I[i]=1 and prev[i]=0.
REQ-017 Edge source i: pending[i] SHALL clear on a PEND write with DAT_I[i]=1, or on a claim of i.
REQ-018 Edge source i: on the same cycle as a clear, a set SHALL win.
REQ-019 A write to MASK or MODE SHALL load DAT_I[NSRC-1:0] at the clock edge and SHALL not alter pending directly.
REQ-020 cand SHALL be the lowest index i with pending[i] & mask[i]; index 0 has the highest priority.
REQ-021 cur SHALL be the lowest index with insvc set, or "none".
REQ-022 IRQ_O SHALL equal: cand exists AND (cur = none OR cand < cur); combinational, no added register.
REQ-023 Latency: a rising edge on IRQ_I in cycle N SHALL give pending at the edge ending cycle N, and IRQ_O high in cycle N+1.
REQ-024 CLAIM read (STB_I=1, WE_I=0, ADD_I=3): DAT_O SHALL equal {1'b1, 28'b0, cand[2:0]} when cand exists, else 32'h0.
REQ-025 At the clock edge of a CLAIM read with cand existing, insvc[cand] SHALL set, and pending[cand] SHALL clear if edge mode.
REQ-026 A CLAIM read with no cand SHALL change no state.
REQ-027 CLAIM is non-nesting-blocked: a claim SHALL occur even when cand >= cur; IRQ_O gating applies only to the request.
REQ-028 EOI write (STB_I & WE_I & ADD_I=3): insvc[DAT_I[2:0]] SHALL clear; DAT_I[2:0] >= NSRC SHALL have no effect.
REQ-029 A PEND write SHALL affect only edge-mode bits.
REQ-030 DAT_O for ADD_I 0/1/2 SHALL be the zero-extended pending/mask/mode; for ADD_I=3 it SHALL follow REQ-024 regardless of STB_I (state changes only with STB_I).
REQ-031 Accesses with STB_I=0 SHALL have no side effects.
REQ-032 Changing mode edge->level SHALL make pending track IRQ_I from the next edge.
REQ-033 Changing mode level->edge SHALL keep pending until it is cleared.

Reset
REQ-034 With RST_I=1 at a clock edge, pending, mask, mode, prev and insvc SHALL clear; IRQ_O SHALL be 0 from the following cycle.
REQ-035 Reset SHALL override any simultaneous bus access or IRQ_I edge.
REQ-036 Reset mid-service SHALL drop insvc with no EOI required.

Verification
REQ-037 Reset, MASK=6'h01, MODE=0, IRQ_I[0] held 1 -> IRQ_O=1 from the second cycle; CLAIM reads 32'h80000000; IRQ_O stays 0 until EOI with DAT_I=0, then returns to 1 while the level persists.
REQ-038 MODE=6'h3F, MASK=6'h3F, one-cycle pulses on IRQ_I[3] and IRQ_I[1] -> PEND=6'h0A; CLAIM reads 0x80000001 then 0x80000003; PEND=0 afterwards.
REQ-039 Nesting: claim 3, insvc={3}; pulse IRQ_I[1] -> IRQ_O=1; pulse IRQ_I[4] alone -> IRQ_O=0 until EOI 3.
REQ-040 Edge source 2 pending; PEND write 6'h04 in the same cycle as a new IRQ_I[2] rising edge -> pending[2] stays 1.
REQ-041 Masked source pending with MASK=0 -> IRQ_O=0 and CLAIM reads 0 with no state change; MASK set -> IRQ_O=1 next cycle.
REQ-042 RST_I asserted with insvc=6'h05 and pending nonzero -> all registers read 0 and IRQ_O=0 on the next cycle.
